// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Receive-side controller behind uart_rx. Each completed character is
// captured with its parity/framing status into a first-word-fall-through
// FIFO. The characters are then presented to the consumer as a valid/ready
// stream. The block also tracks FIFO overruns and keeps a saturating count
// of discarded characters.
//
// Ports:
//   clk            system clock (same clock as uart_rx)
//   reset          asynchronous active-high reset, clears all state
//   enable         accept new characters when 1
//   flush          synchronous single-cycle clear of FIFO, overrun, drop_count
//   rx_data        character from uart_rx
//   rx_data_ready  uart_rx data_ready, may be high for several clk cycles
//   rx_parity_err  uart_rx parity status
//   rx_frame_err   uart_rx framing status
//   m_data         head-of-FIFO character (zero while m_valid=0)
//   m_parity_err   parity status stored with the head character
//   m_frame_err    framing status stored with the head character
//   m_valid        FIFO non-empty
//   m_ready        consumer takes the head when m_valid & m_ready
//   level          current occupancy, 0..FIFO_DEPTH
//   overrun        sticky, set when a character arrives while full
//   overrun_clr    clears overrun; a set in the same cycle wins
//   drop_count     saturating count of discarded characters
module uart_rx_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int DROP_ERRORED = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          flush,
  input  logic [DATA_BITS-1:0]          rx_data,
  input  logic                          rx_data_ready,
  input  logic                          rx_parity_err,
  input  logic                          rx_frame_err,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_parity_err,
  output logic                          m_frame_err,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic [7:0]                    drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = DATA_BITS + 2;
  localparam logic [PW-1:0] FULL_LEVEL = PW'(FIFO_DEPTH);
  localparam logic DROP_EN = (DROP_ERRORED != 0);

  // Reject depths the pointer arithmetic cannot handle.
  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_ctrl: FIFO_DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          rdy_q;
  logic [WW-1:0] head;

  logic rx_event;
  logic push_req;
  logic err_drop;
  logic ovf_drop;
  logic push;
  logic pop;
  logic full;

  // Pointers carry one extra bit so full and empty stay distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == FULL_LEVEL);
  assign m_valid = (level != '0);
  assign pop     = m_valid & m_ready;

  // Outputs are forced to zero while empty. Unwritten memory then never
  // shows up on the stream, which also gives clean reset values.
  assign head         = mem[rd_ptr[AW-1:0]];
  assign m_data       = m_valid ? head[DATA_BITS-1:0] : '0;
  assign m_parity_err = m_valid ? head[DATA_BITS]     : 1'b0;
  assign m_frame_err  = m_valid ? head[DATA_BITS+1]   : 1'b0;

  // One event per character, however long data_ready is held.
  assign rx_event = rx_data_ready & ~rdy_q;

  // Push decision in priority order: flush, enable, error discard, overrun.
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  always_comb begin
    push_req = rx_event & ~flush & enable;
    err_drop = push_req & DROP_EN & (rx_parity_err | rx_frame_err);
    ovf_drop = push_req & ~err_drop & full & ~pop;
    push     = push_req & ~err_drop & ~ovf_drop;
  end

  // Edge-detect register runs regardless of enable or flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdy_q <= 1'b0;
    else       rdy_q <= rx_data_ready;
  end

  // Storage needs no reset; its contents are only visible through m_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {rx_frame_err, rx_parity_err, rx_data};
  end

  // Pointers, sticky overrun and the saturating drop counter. A flush
  // overrides every other update in its cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overrun    <= 1'b0;
      drop_count <= 8'd0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overrun    <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (ovf_drop)         overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
      if ((err_drop | ovf_drop) && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl. Two instances share all inputs:
// d0 keeps errored characters (DROP_ERRORED=0) and d1 discards them
// (DROP_ERRORED=1). Both use FIFO_DEPTH=4. Directed steps come first,
// then a randomized phase. A simple queue model tracks the expected state.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset, enable, flush, rx_data_ready, rx_parity_err, rx_frame_err;
  logic m_ready, overrun_clr;
  logic [7:0] rx_data;

  logic [7:0]    m_data_o     [2];
  logic          m_parity_o   [2];
  logic          m_frame_o    [2];
  logic          m_valid_o    [2];
  logic [LW-1:0] level_o      [2];
  logic          overrun_o    [2];
  logic [7:0]    drop_o       [2];

  // Reference model: per instance, an ordered list of stored words plus
  // the overrun flag and the drop count.
  logic [9:0] mq [2][DEPTH];
  int         mcnt  [2];
  int         mdrop [2];
  bit         movr  [2];
  bit         mlast;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .DROP_ERRORED(0)) d0 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .rx_data(rx_data), .rx_data_ready(rx_data_ready),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .m_data(m_data_o[0]), .m_parity_err(m_parity_o[0]), .m_frame_err(m_frame_o[0]),
    .m_valid(m_valid_o[0]), .m_ready(m_ready), .level(level_o[0]),
    .overrun(overrun_o[0]), .overrun_clr(overrun_clr), .drop_count(drop_o[0])
  );

  uart_rx_ctrl #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .DROP_ERRORED(1)) d1 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .rx_data(rx_data), .rx_data_ready(rx_data_ready),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .m_data(m_data_o[1]), .m_parity_err(m_parity_o[1]), .m_frame_err(m_frame_o[1]),
    .m_valid(m_valid_o[1]), .m_ready(m_ready), .level(level_o[1]),
    .overrun(overrun_o[1]), .overrun_clr(overrun_clr), .drop_count(drop_o[1])
  );

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k]  = 0;
      mdrop[k] = 0;
      movr[k]  = 0;
    end
    mlast = 0;
  endtask

  // One clock edge of the model, using the inputs as they are at the edge.
  task automatic modelStep();
    bit ev;
    ev = rx_data_ready && !mlast;
    for (int k = 0; k < 2; k++) begin
      bit popping;
      bit was_full;
      bit set_ovr;
      popping  = m_ready && (mcnt[k] > 0);
      was_full = (mcnt[k] == DEPTH);
      set_ovr  = 0;
      if (flush) begin
        mcnt[k]  = 0;
        mdrop[k] = 0;
        movr[k]  = 0;
      end else begin
        if (popping) begin
          for (int i = 0; i < DEPTH - 1; i++) mq[k][i] = mq[k][i+1];
          mcnt[k]--;
        end
        if (ev && enable) begin
          if (k == 1 && (rx_parity_err || rx_frame_err)) begin
            if (mdrop[k] < 255) mdrop[k]++;
          end else if (was_full && !popping) begin
            set_ovr = 1;
            movr[k] = 1;
            if (mdrop[k] < 255) mdrop[k]++;
          end else begin
            mq[k][mcnt[k]] = {rx_frame_err, rx_parity_err, rx_data};
            mcnt[k]++;
          end
        end
        if (overrun_clr && !set_ovr) movr[k] = 0;
      end
    end
    mlast = rx_data_ready;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("d%0d_valid", k),   32'(m_valid_o[k]), 32'(mcnt[k] > 0));
      checkOutput($sformatf("d%0d_level", k),   32'(level_o[k]),   32'(mcnt[k]));
      checkOutput($sformatf("d%0d_overrun", k), 32'(overrun_o[k]), 32'(movr[k]));
      checkOutput($sformatf("d%0d_drop", k),    32'(drop_o[k]),    32'(mdrop[k]));
      if (mcnt[k] > 0) begin
        checkOutput($sformatf("d%0d_data", k),  32'(m_data_o[k]),   32'(mq[k][0][7:0]));
        checkOutput($sformatf("d%0d_perr", k),  32'(m_parity_o[k]), 32'(mq[k][0][8]));
        checkOutput($sformatf("d%0d_ferr", k),  32'(m_frame_o[k]),  32'(mq[k][0][9]));
      end
    end
  endtask

  task automatic checkReset(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("%s_d%0d_valid", tag, k),   32'(m_valid_o[k]),  0);
      checkOutput($sformatf("%s_d%0d_level", tag, k),   32'(level_o[k]),    0);
      checkOutput($sformatf("%s_d%0d_overrun", tag, k), 32'(overrun_o[k]),  0);
      checkOutput($sformatf("%s_d%0d_drop", tag, k),    32'(drop_o[k]),     0);
      checkOutput($sformatf("%s_d%0d_data", tag, k),    32'(m_data_o[k]),   0);
      checkOutput($sformatf("%s_d%0d_perr", tag, k),    32'(m_parity_o[k]), 0);
      checkOutput($sformatf("%s_d%0d_ferr", tag, k),    32'(m_frame_o[k]),  0);
    end
  endtask

  // Run clock cycles with the current inputs, then compare against the model.
  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      if (reset) modelReset();
      else       modelStep();
      #1;
      checkAll();
    end
  endtask

  task automatic sendChar(input logic [7:0] d, input logic p, input logic f,
                          input int hold);
    rx_data       = d;
    rx_parity_err = p;
    rx_frame_err  = f;
    rx_data_ready = 1'b1;
    applyStimulus(hold);
    rx_data_ready = 1'b0;
    applyStimulus(2);
  endtask

  task automatic popOne();
    m_ready = 1'b1;
    applyStimulus(1);
    m_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; flush = 1'b0; rx_data_ready = 1'b0;
    rx_data = 8'h00; rx_parity_err = 1'b0; rx_frame_err = 1'b0;
    m_ready = 1'b0; overrun_clr = 1'b0;
    modelReset();
    #1;
    checkReset("por");
    applyStimulus(3);
    reset = 1'b0;
    applyStimulus(2);

    // Single clean character, data_ready held for 16 clocks.
    sendChar(8'hA5, 1'b0, 1'b0, 16);
    checkOutput("single_level", 32'(level_o[0]), 1);
    checkOutput("single_data", 32'(m_data_o[0]), 32'h A5);
    popOne();
    checkOutput("single_popped", 32'(m_valid_o[0]), 0);

    // Parity error: kept by d0, discarded and counted by d1.
    sendChar(8'h3C, 1'b1, 1'b0, 4);
    checkOutput("perr_keep_level", 32'(level_o[0]), 1);
    checkOutput("perr_keep_flag", 32'(m_parity_o[0]), 1);
    checkOutput("perr_keep_data", 32'(m_data_o[0]), 32'h3C);
    checkOutput("perr_drop_level", 32'(level_o[1]), 0);
    checkOutput("perr_drop_count", 32'(drop_o[1]), 1);
    flush = 1'b1; applyStimulus(1); flush = 1'b0;

    // Overrun: five characters into a four-entry FIFO.
    for (int i = 1; i <= 5; i++) sendChar(8'(i), 1'b0, 1'b0, 2);
    checkOutput("ovr_level", 32'(level_o[0]), 4);
    checkOutput("ovr_flag", 32'(overrun_o[0]), 1);
    checkOutput("ovr_drop", 32'(drop_o[0]), 1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("ovr_order", 32'(m_data_o[0]), i);
      popOne();
    end

    // Three entries with overrun still set, then a disabled character.
    for (int i = 0; i < 3; i++) sendChar(8'h40 + 8'(i), 1'b0, 1'b0, 3);
    enable = 1'b0;
    sendChar(8'h77, 1'b0, 1'b0, 3);
    enable = 1'b1;
    checkOutput("disabled_level", 32'(level_o[0]), 3);
    checkOutput("disabled_drop", 32'(drop_o[0]), 1);

    // Flush with a character event in the same cycle.
    rx_data = 8'h99; rx_data_ready = 1'b1; flush = 1'b1;
    applyStimulus(1);
    flush = 1'b0; rx_data_ready = 1'b0;
    applyStimulus(1);
    checkOutput("flush_level", 32'(level_o[0]), 0);
    checkOutput("flush_overrun", 32'(overrun_o[0]), 0);
    checkOutput("flush_drop", 32'(drop_o[0]), 0);
    checkOutput("flush_valid", 32'(m_valid_o[0]), 0);

    // Full FIFO, with an event and a pop in the same cycle.
    for (int i = 0; i < 4; i++) sendChar(8'h11 + 8'(i), 1'b0, 1'b0, 2);
    rx_data = 8'h15; rx_data_ready = 1'b1; m_ready = 1'b1;
    applyStimulus(1);
    m_ready = 1'b0; rx_data_ready = 1'b0;
    applyStimulus(1);
    checkOutput("fullpop_level", 32'(level_o[0]), 4);
    checkOutput("fullpop_overrun", 32'(overrun_o[0]), 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("fullpop_order", 32'(m_data_o[0]), 32'h12 + i);
      popOne();
    end

    // Saturation of drop_count, then a reset in the middle of a character.
    for (int i = 0; i < 4; i++) sendChar(8'(i), 1'b0, 1'b0, 1);
    for (int i = 0; i < 300; i++) sendChar(8'hEE, 1'b0, 1'b0, 1);
    checkOutput("sat_drop", 32'(drop_o[0]), 255);
    rx_data = 8'h5A; rx_data_ready = 1'b1;
    applyStimulus(3);
    #2 reset = 1'b1;
    #1 modelReset();
    checkReset("midreset");
    rx_data_ready = 1'b0;
    applyStimulus(2);
    reset = 1'b0;
    applyStimulus(1);
    sendChar(8'hC3, 1'b0, 1'b1, 5);
    checkOutput("after_reset_level", 32'(level_o[0]), 1);
    checkOutput("after_reset_data", 32'(m_data_o[0]), 32'hC3);
    checkOutput("after_reset_ferr", 32'(m_frame_o[0]), 1);
    checkOutput("after_reset_d1_drop", 32'(drop_o[1]), 1);

    // Randomized phase: random characters and random consumer/control activity.
    for (int n = 0; n < 200; n++) begin
      int hold;
      int gap;
      rx_data       = 8'($urandom);
      rx_parity_err = ($urandom_range(0, 5) == 0);
      rx_frame_err  = ($urandom_range(0, 7) == 0);
      hold          = $urandom_range(1, 6);
      gap           = $urandom_range(1, 3);
      for (int c = 0; c < hold + gap; c++) begin
        rx_data_ready = (c < hold);
        m_ready       = ($urandom_range(0, 2) == 0);
        overrun_clr   = ($urandom_range(0, 9) == 0);
        flush         = ($urandom_range(0, 39) == 0);
        enable        = ($urandom_range(0, 7) != 0);
        applyStimulus(1);
      end
    end
    rx_data_ready = 1'b0; m_ready = 1'b0; overrun_clr = 1'b0;
    flush = 1'b0; enable = 1'b1;
    applyStimulus(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
